// File: rtl/argmax_stream_pipe.sv
// -----------------------------------------------------------------------------
// argmax_stream_pipe
//
// Pipelined arg-max over a stream of vectors. Each beat carries NUM_DATA lanes
// of DATA_WIDTH bits. A vector spans one or more beats, closed by in_last or
// forcibly after MAX_BEATS beats. The block reports the winning value and its
// global index (beat_number*NUM_DATA + lane) for every vector.
//
// Pipeline:
//   LVL registered compare levels (binary tree)
//   -> accumulator (running best across the beats of a vector)
//   -> output register (held until out_valid && out_ready)
//
// Latency from acceptance of the final beat to out_valid is LVL+1 cycles.
// Tie rule: lowest lane inside a beat, earliest beat across beats.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid && in_ready
//   in_data    NUM_DATA lanes, lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   in_last    final beat of the vector
//   mode_min   (ARGMAX_MIN_MODE_EN only) select arg-min for this vector,
//              sampled on the first beat of each vector
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out_data   winning value
//   out_idx    winning global index
//   out_trunc  vector was force-terminated at MAX_BEATS
//
// Build option: define ARGMAX_MIN_MODE_EN to add the mode_min port.
// -----------------------------------------------------------------------------
module argmax_stream_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DATA   = 16,
    parameter int SIGNED     = 0,
    parameter int MAX_BEATS  = 4,
    localparam int LVL  = $clog2(NUM_DATA),
    localparam int IDXW = (NUM_DATA * MAX_BEATS > 1) ? $clog2(NUM_DATA * MAX_BEATS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef ARGMAX_MIN_MODE_EN
    input  logic                           mode_min,
`endif
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*NUM_DATA-1:0] in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDXW-1:0]                out_idx,
    output logic                           out_trunc
);

    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int NN = NUM_DATA - 1;        // internal tree nodes
    localparam int NC = 2 * NUM_DATA - 1;    // internal nodes + leaves

    // a strictly better than b (strictly greater, or strictly smaller in min mode)
    function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b,
                                    input logic                  mn);
        logic gt;
        logic lt;
        if (SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mn ? lt : gt;
    endfunction

    function automatic int flog2(input int v);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if (v >= (1 << i)) r = i;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;
    logic advance;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !reset && !stall;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Beat counter and per-beat tags
    // ------------------------------------------------------------------
    logic [BW-1:0] beat_cnt;
    logic          beat_first;
    logic          beat_at_max;
    logic          beat_last;
    logic          beat_trunc;
    logic          beat_mode;

    assign beat_first  = (beat_cnt == '0);
    assign beat_at_max = (beat_cnt == BW'(MAX_BEATS - 1));
    assign beat_trunc  = beat_at_max && !in_last;
    assign beat_last   = in_last || beat_at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
        end
    end

`ifdef ARGMAX_MIN_MODE_EN
    // Mode is latched on the first beat so later beats of the vector reuse it.
    logic vec_mode;

    assign beat_mode = beat_first ? mode_min : vec_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_mode <= 1'b0;
        end else if (accept && beat_first) begin
            vec_mode <= mode_min;
        end
    end
`else
    assign beat_mode = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-stage beat metadata. Bit 0 of each chain is the beat entering
    // stage 1; bit s is the beat held in stage s (bit LVL feeds the
    // accumulator).
    // ------------------------------------------------------------------
    logic [LVL-1:0]    st_valid;
    logic [LVL-1:0]    st_first;
    logic [LVL-1:0]    st_last;
    logic [LVL-1:0]    st_trunc;
    logic [LVL-1:0]    st_mode;
    logic [LVL*BW-1:0] st_beat;

    logic [LVL:0]          v_chain;
    logic [LVL:0]          f_chain;
    logic [LVL:0]          l_chain;
    logic [LVL:0]          t_chain;
    logic [LVL:0]          m_chain;
    logic [(LVL+1)*BW-1:0] b_chain;

    assign v_chain = {st_valid, accept};
    assign f_chain = {st_first, beat_first};
    assign l_chain = {st_last,  beat_last};
    assign t_chain = {st_trunc, beat_trunc};
    assign m_chain = {st_mode,  beat_mode};
    assign b_chain = {st_beat,  beat_cnt};

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= '0;
        end else if (advance) begin
            st_valid <= v_chain[LVL-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            st_first <= f_chain[LVL-1:0];
            st_last  <= l_chain[LVL-1:0];
            st_trunc <= t_chain[LVL-1:0];
            st_mode  <= m_chain[LVL-1:0];
            st_beat  <= b_chain[LVL*BW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Compare tree, heap layout: heap node n lives at cand[n-1]. Nodes
    // 1..NUM_DATA-1 are registers, NUM_DATA..2*NUM_DATA-1 are the input
    // lanes. Node n at depth flog2(n) belongs to stage LVL-depth, so each
    // tree level is one pipeline register and the root is the last stage.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] node_val [NN];
    logic [LVL-1:0]        node_idx [NN];
    logic [DATA_WIDTH-1:0] cand_val [NC];
    logic [LVL-1:0]        cand_idx [NC];

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            cand_val[i] = node_val[i];
            cand_idx[i] = node_idx[i];
        end
        for (int l = 0; l < NUM_DATA; l++) begin
            cand_val[NN+l] = in_data[DATA_WIDTH*l +: DATA_WIDTH];
            cand_idx[NN+l] = LVL'(l);
        end
    end

    // Right child (higher lanes) wins only when strictly better.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int n = 1; n < NUM_DATA; n++) begin
                if (better(cand_val[2*n], cand_val[2*n-1], m_chain[LVL-1-flog2(n)])) begin
                    node_val[n-1] <= cand_val[2*n];
                    node_idx[n-1] <= cand_idx[2*n];
                end else begin
                    node_val[n-1] <= cand_val[2*n-1];
                    node_idx[n-1] <= cand_idx[2*n-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator: running best of the current vector
    // ------------------------------------------------------------------
    logic                  acc_valid;
    logic                  acc_last;
    logic                  acc_trunc;
    logic [DATA_WIDTH-1:0] acc_val;
    logic [IDXW-1:0]       acc_idx;
    logic [BW+LVL-1:0]     root_gidx;
    logic                  acc_take;

    assign root_gidx = {b_chain[LVL*BW +: BW], cand_idx[0]};
    assign acc_take  = v_chain[LVL] &&
                       (f_chain[LVL] || better(cand_val[0], acc_val, m_chain[LVL]));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
            acc_trunc <= 1'b0;
            acc_val   <= '0;
            acc_idx   <= '0;
        end else if (advance) begin
            acc_valid <= v_chain[LVL];
            if (v_chain[LVL]) begin
                acc_last  <= l_chain[LVL];
                acc_trunc <= t_chain[LVL];
            end
            if (acc_take) begin
                acc_val <= cand_val[0];
                acc_idx <= IDXW'(root_gidx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads when the final beat leaves the accumulator.
    // advance is high whenever the held result is consumed, so a new
    // result can replace it in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_trunc <= 1'b0;
        end else if (advance) begin
            out_valid <= acc_valid && acc_last;
            if (acc_valid && acc_last) begin
                out_data  <= acc_val;
                out_idx   <= acc_idx;
                out_trunc <= acc_trunc;
            end
        end
    end

endmodule

// File: tb/tb_argmax_stream_pipe.sv
module tb_argmax_stream_pipe;

    localparam int DW   = 8;
    localparam int ND   = 16;
    localparam int MAXB = 4;
    localparam int IW   = 6;

    logic          clk = 1'b0;
    logic          reset;

    logic          in_valid, in_ready, in_last, out_valid, out_ready, out_trunc;
    logic [127:0]  in_data;
    logic [7:0]    out_data;
    logic [IW-1:0] out_idx;

    logic          s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_trunc;
    logic [127:0]  s_in_data;
    logic [7:0]    s_out_data;
    logic [IW-1:0] s_out_idx;

    always #5 clk = ~clk;

    argmax_stream_pipe #(.DATA_WIDTH(DW), .NUM_DATA(ND), .SIGNED(0), .MAX_BEATS(MAXB)) u_dut (
        .clk(clk), .reset(reset),
`ifdef ARGMAX_MIN_MODE_EN
        .mode_min(1'b0),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_trunc(out_trunc)
    );

    argmax_stream_pipe #(.DATA_WIDTH(DW), .NUM_DATA(ND), .SIGNED(1), .MAX_BEATS(MAXB)) u_sdut (
        .clk(clk), .reset(reset),
`ifdef ARGMAX_MIN_MODE_EN
        .mode_min(1'b0),
`endif
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_trunc(s_out_trunc)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_res  = 0;

    task automatic check_eq(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model (unsigned DUT) ----------------
    typedef struct { int d; int idx; int tr; } res_t;
    res_t exp_q[$];
    int   m_cnt  = 0;
    int   m_best = 0;
    int   m_idx  = 0;
    bit   m_have = 0;

    // Linear scan in global index order with strict '>' gives the
    // lowest-lane / earliest-beat tie rule directly.
    task automatic model_beat(input logic [127:0] d, input logic last);
        int   v;
        res_t r;
        bit   tr;
        for (int l = 0; l < ND; l++) begin
            v = int'(d[8*l +: 8]);
            if (!m_have || v > m_best) begin
                m_best = v;
                m_idx  = m_cnt * ND + l;
                m_have = 1;
            end
        end
        tr = !last && (m_cnt == MAXB - 1);
        if (last || tr) begin
            r.d = m_best; r.idx = m_idx; r.tr = int'(tr);
            exp_q.push_back(r);
            m_cnt = 0; m_have = 0;
        end else begin
            m_cnt++;
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            exp_q.delete();
            m_cnt = 0; m_have = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("mdl_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("mdl_data",  int'(out_data),  e.d);
                    check_eq("mdl_idx",   int'(out_idx),   e.idx);
                    check_eq("mdl_trunc", int'(out_trunc), e.tr);
                    n_res++;
                end
            end
            if (in_valid && in_ready) model_beat(in_data, in_last);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] mk(input logic [7:0] fill, input int lane, input logic [7:0] v);
        logic [127:0] r;
        for (int l = 0; l < ND; l++) r[8*l +: 8] = (l == lane) ? v : fill;
        return r;
    endfunction

    function automatic logic [127:0] rnd_beat();
        logic [127:0] r;
        bit narrow;
        narrow = ($urandom % 2) == 1;
        for (int l = 0; l < ND; l++) r[8*l +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
        return r;
    endfunction

    // Called at posedge+1; samples ready at negedge, returns at posedge+1.
    task automatic send_beat(input logic sgn, input logic [127:0] d, input logic last, output int cyc);
        logic rdy;
        cyc = 0;
        if (sgn) begin s_in_valid = 1; s_in_data = d; s_in_last = last; end
        else     begin in_valid   = 1; in_data   = d; in_last   = last; end
        do begin
            @(negedge clk);
            rdy = sgn ? s_in_ready : in_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!rdy && cyc < 300);
        if (!rdy) check_eq("send_timeout", 0, 1);
        in_valid = 0; s_in_valid = 0;
    endtask

    typedef struct {
        logic         sgn;
        logic [127:0] data;
        logic         last;
        logic         check;
        logic [7:0]   e_data;
        int           e_idx;
        logic         e_trunc;
    } vec_t;

    task automatic run_rec(input vec_t r, input string nm);
        int w, lat;
        send_beat(r.sgn, r.data, r.last, w);
        if (r.check) begin
            lat = 0;
            while (!(r.sgn ? s_out_valid : out_valid) && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            check_eq({nm, "_latency"}, lat, 5);
            check_eq({nm, "_data"},  int'(r.sgn ? s_out_data  : out_data),  int'(r.e_data));
            check_eq({nm, "_idx"},   int'(r.sgn ? s_out_idx   : out_idx),   r.e_idx);
            check_eq({nm, "_trunc"}, int'(r.sgn ? s_out_trunc : out_trunc), int'(r.e_trunc));
        end
    endtask

    task automatic drain(input string nm);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 200) begin @(posedge clk); #1; c++; end
        check_eq({nm, "_drain_timeout"}, int'(c >= 200), 0);
    endtask

    vec_t tbl [18];

    initial begin
        logic [127:0] tmp;
        logic [7:0]   sv;
        logic [IW-1:0] si;
        int w, tot, base, lat;
        bit acc;

        reset = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        s_in_valid = 0; s_in_data = '0; s_in_last = 0; s_out_ready = 1;

        // ---- vector table ----
        for (int l = 0; l < ND; l++) tmp[8*l +: 8] = 8'(l * 3);
        tmp[8*9 +: 8] = 8'hF0;
        tbl[0]  = '{1'b0, tmp,                 1'b1, 1'b1, 8'hF0, 9,  1'b0};
        tbl[1]  = '{1'b0, mk(8'h55, 0, 8'h55), 1'b1, 1'b1, 8'h55, 0,  1'b0};
        tbl[2]  = '{1'b0, mk(8'h10, 2, 8'h40), 1'b0, 1'b0, 8'h00, 0,  1'b0};
        tbl[3]  = '{1'b0, mk(8'h10, 7, 8'h90), 1'b0, 1'b0, 8'h00, 0,  1'b0};
        tbl[4]  = '{1'b0, mk(8'h00, 1, 8'h90), 1'b1, 1'b1, 8'h90, 23, 1'b0};
        tbl[5]  = '{1'b0, mk(8'h10, 0, 8'h30), 1'b0, 1'b0, 8'h00, 0,  1'b0};
        tbl[6]  = '{1'b0, mk(8'h20, 9, 8'h50), 1'b0, 1'b0, 8'h00, 0,  1'b0};
        tbl[7]  = '{1'b0, mk(8'h05, 3, 8'hE0), 1'b0, 1'b0, 8'h00, 0,  1'b0};
        tbl[8]  = '{1'b0, mk(8'h01, 12, 8'h60), 1'b0, 1'b1, 8'hE0, 35, 1'b1};
        tbl[9]  = '{1'b0, mk(8'h00, 5, 8'h22), 1'b1, 1'b1, 8'h22, 5,  1'b0};
        tbl[10] = '{1'b0, mk(8'h00, 0, 8'h00), 1'b1, 1'b1, 8'h00, 0,  1'b0};
        tbl[11] = '{1'b0, mk(8'hFF, 0, 8'hFF), 1'b1, 1'b1, 8'hFF, 0,  1'b0};
        tbl[12] = '{1'b0, mk(8'hFE, 15, 8'hFF), 1'b1, 1'b1, 8'hFF, 15, 1'b0};
        tmp = mk(8'hFF, 4, 8'h01);
        tmp[8*5 +: 8] = 8'h80;
        tbl[13] = '{1'b1, tmp,                 1'b1, 1'b1, 8'h01, 4,  1'b0};
        tbl[14] = '{1'b1, mk(8'h80, 15, 8'h81), 1'b1, 1'b1, 8'h81, 15, 1'b0};
        tbl[15] = '{1'b1, mk(8'h80, 0, 8'h80), 1'b1, 1'b1, 8'h80, 0,  1'b0};
        tbl[16] = '{1'b1, mk(8'hFF, 3, 8'h7F), 1'b1, 1'b1, 8'h7F, 3,  1'b0};
        tbl[17] = '{1'b0, mk(8'h80, 3, 8'h7F), 1'b1, 1'b1, 8'h80, 0,  1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",   int'(in_ready), 0);
        check_eq("rst_s_in_ready", int'(s_in_ready), 0);
        check_eq("rst_out_valid",  int'(out_valid), 0);
        check_eq("rst_out_data",   int'(out_data), 0);
        check_eq("rst_out_idx",    int'(out_idx), 0);
        check_eq("rst_out_trunc",  int'(out_trunc), 0);
        reset = 0;
        #1;
        check_eq("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // ---- directed table ----
        for (int i = 0; i < 18; i++) run_rec(tbl[i], $sformatf("tbl%0d", i));
        drain("tbl");

        // ---- throughput: single-beat vectors, one per cycle ----
        tot = 0;
        for (int k = 0; k < 8; k++) begin
            send_beat(1'b0, rnd_beat(), 1'b1, w);
            tot += w;
        end
        check_eq("tput_cycles", tot, 8);
        drain("tput");

        // ---- stall with 10 single-beat vectors ----
        base = n_res;
        out_ready = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) send_beat(1'b0, rnd_beat(), 1'b1, w);
            end
            begin
                lat = 0;
                while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
                check_eq("stall_first_valid", int'(out_valid), 1);
                check_eq("stall_in_ready", int'(in_ready), 0);
                sv = out_data; si = out_idx;
                repeat (15) begin
                    @(posedge clk); #1;
                    check_eq("stall_hold",
                             int'(out_valid && !in_ready && out_data == sv && out_idx == si), 1);
                end
                @(posedge clk); #3;
                out_ready = 1;
            end
        join
        drain("stall");
        check_eq("stall_result_count", n_res - base, 10);

        // ---- reset mid-vector ----
        send_beat(1'b0, mk(8'h00, 2, 8'hC0), 1'b0, w);
        send_beat(1'b0, mk(8'h00, 4, 8'hD0), 1'b0, w);
        reset = 1;
        #1;
        check_eq("midvec_rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 0;
        tot = 0;
        repeat (10) begin @(posedge clk); #1; tot += int'(out_valid); end
        check_eq("midvec_no_output", tot, 0);
        run_rec('{1'b0, mk(8'h00, 6, 8'h33), 1'b1, 1'b1, 8'h33, 6, 1'b0}, "after_midvec_rst");
        drain("midvec");

        // ---- reset mid-stall ----
        out_ready = 0;
        send_beat(1'b0, mk(8'h11, 8, 8'h99), 1'b1, w);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check_eq("midstall_valid", int'(out_valid), 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check_eq("midstall_cleared", int'(out_valid), 0);
        out_ready = 1;
        run_rec('{1'b0, mk(8'h02, 11, 8'h07), 1'b1, 1'b1, 8'h07, 11, 1'b0}, "after_midstall_rst");
        drain("midstall");

        // ---- randomized multi-beat traffic with random backpressure ----
        base = n_res;
        in_valid = 0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid && ($urandom % 4) != 0) begin
                in_valid = 1;
                in_data  = rnd_beat();
                in_last  = ($urandom % 3) == 0;
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 0;
        end
        in_valid = 0;
        out_ready = 1;
        drain("random");
        check_eq("random_some_results", int'(n_res - base > 20), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
